// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter and its prescaler.
package counter_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Bits needed to hold prescaler values 0..prescale-1, never less than one.
    function automatic int prescale_width(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/count_prescaler.sv
// Divides enabled cycles by PRESCALE: tick is high on the last enabled cycle of each group.
module count_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              PW   = prescale_width(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // clr beats en so a clear or load restarts the division from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with wrap or saturate at MAX_COUNT, optional
// prescaling, synchronous clear/load, terminal-count flag and roll-over pulse.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter bit SATURATE  = 1'b0,
    parameter int PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    logic step;
    logic at_end;

    generate
        if (PRESCALE == 1) begin : g_direct
            assign step = en;
        end else begin : g_prescale
            count_prescaler #(
                .PRESCALE (PRESCALE)
            ) u_prescaler (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .clr  (sclr | load),
                .tick (step)
            );
        end
    endgenerate

    assign at_end = ((up_dn == CNT_UP) && (q == MAX_Q)) ||
                    ((up_dn == CNT_DN) && (q == '0));
    assign tc     = step && at_end;

    // wrap defaults low each edge, so it is a single-cycle pulse after a roll-over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (sclr) begin
                q <= '0;
            end else if (load) begin
                q <= (load_val > MAX_Q) ? MAX_Q : load_val;
            end else if (step) begin
                if (at_end) begin
                    if (!SATURATE) begin
                        q    <= (up_dn == CNT_UP) ? '0 : MAX_Q;
                        wrap <= 1'b1;
                    end
                end else begin
                    q <= (up_dn == CNT_UP) ? q + 1'b1 : q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: four parameterisations share one stimulus stream
// and are compared every cycle against an integer model, plus hand-computed spot checks.
module tb_param_updown_counter;

    localparam int N = 4;
    // Per-instance configuration: terminal value, saturate flag, prescale.
    localparam int CFG_MAX [N] = '{7, 5, 5, 7};
    localparam int CFG_SAT [N] = '{0, 1, 0, 0};
    localparam int CFG_PRE [N] = '{1, 1, 1, 3};

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       sclr;
    logic       load;
    logic [2:0] load_val;

    logic [2:0] dq [N];
    logic       dt [N];
    logic       dw [N];

    int  tests_run    = 0;
    int  tests_failed = 0;
    bit  checking     = 1'b0;

    int  m_q   [N];
    int  m_pre [N];
    bit  m_wrap[N];

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(3)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sclr(sclr), .load(load),
        .load_val(load_val), .q(dq[0]), .tc(dt[0]), .wrap(dw[0]));

    param_updown_counter #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sclr(sclr), .load(load),
        .load_val(load_val), .q(dq[1]), .tc(dt[1]), .wrap(dw[1]));

    param_updown_counter #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sclr(sclr), .load(load),
        .load_val(load_val), .q(dq[2]), .tc(dt[2]), .wrap(dw[2]));

    param_updown_counter #(.WIDTH(3), .PRESCALE(3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sclr(sclr), .load(load),
        .load_val(load_val), .q(dq[3]), .tc(dt[3]), .wrap(dw[3]));

    task automatic check_output(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference behaviour: plain integer counting from the rules of the counter.
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < N; i++) begin
            if (!rst) begin
                m_q[i] = 0; m_pre[i] = 0; m_wrap[i] = 1'b0;
            end else begin
                m_wrap[i] = 1'b0;
                if (sclr) begin
                    m_q[i] = 0; m_pre[i] = 0;
                end else if (load) begin
                    m_q[i] = (int'(load_val) > CFG_MAX[i]) ? CFG_MAX[i] : int'(load_val);
                    m_pre[i] = 0;
                end else if (en) begin
                    if (m_pre[i] + 1 < CFG_PRE[i]) begin
                        m_pre[i]++;
                    end else begin
                        m_pre[i] = 0;
                        if (up_dn) begin
                            if (m_q[i] < CFG_MAX[i]) m_q[i]++;
                            else if (CFG_SAT[i] == 0) begin m_q[i] = 0; m_wrap[i] = 1'b1; end
                        end else begin
                            if (m_q[i] > 0) m_q[i]--;
                            else if (CFG_SAT[i] == 0) begin m_q[i] = CFG_MAX[i]; m_wrap[i] = 1'b1; end
                        end
                    end
                end
            end
        end
    end

    function automatic int model_tc(input int i);
        bit last_pre;
        last_pre = (m_pre[i] == CFG_PRE[i] - 1);
        return int'(en && last_pre &&
                    ((up_dn && m_q[i] == CFG_MAX[i]) || (!up_dn && m_q[i] == 0)));
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < N; i++) begin
                check_output($sformatf("q[%0d]", i),    int'(dq[i]), m_q[i]);
                check_output($sformatf("wrap[%0d]", i), int'(dw[i]), int'(m_wrap[i]));
                check_output($sformatf("tc[%0d]", i),   int'(dt[i]), model_tc(i));
            end
        end
    end

    // Drive one cycle of inputs shortly after a rising edge, then move past the next edge.
    task automatic apply_stimulus(input logic e, input logic u, input logic s,
                                  input logic l, input logic [2:0] v);
        en = e; up_dn = u; sclr = s; load = l; load_val = v;
        @(posedge clk);
        #2;
    endtask

    typedef struct { logic e; logic u; logic s; logic l; logic [2:0] v; } vec_t;
    vec_t mix [12];

    initial begin
        int exp_a [9];
        exp_a = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        mix = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0}, '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0}, '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 3'd4}, '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0}, '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0},
            '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0}, '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0}, '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0}
        };

        rst = 1'b0; en = 1'b0; up_dn = 1'b1; sclr = 1'b0; load = 1'b0; load_val = '0;
        repeat (2) @(posedge clk);
        #2;
        check_output("reset q", int'(dq[0]), 0);
        check_output("reset wrap", int'(dw[0]), 0);
        rst = 1'b1;
        checking = 1'b1;

        // Free-running up count through one roll-over.
        for (int k = 0; k < 9; k++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
            check_output($sformatf("up q step%0d", k + 1), int'(dq[0]), exp_a[k]);
            check_output($sformatf("up wrap step%0d", k + 1), int'(dw[0]), (k == 7) ? 1 : 0);
            if (k == 6) check_output("tc at 7", int'(dt[0]), 1);
        end
        check_output("sat q held", int'(dq[1]), 5);
        check_output("sat tc held", int'(dt[1]), 1);
        check_output("prescale q after 9", int'(dq[3]), 3);

        // Clear wins over enable, then count down from zero.
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        check_output("sclr q", int'(dq[0]), 0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
            check_output($sformatf("sat down q%0d", k), int'(dq[1]), 0);
            check_output($sformatf("sat down wrap%0d", k), int'(dw[1]), 0);
        end
        check_output("sat down tc", int'(dt[1]), 1);
        check_output("wrap down q", int'(dq[2]), 3);
        check_output("prescale down q", int'(dq[3]), 7);
        check_output("prescale down wrap", int'(dw[3]), 1);

        // Load with clamping, a step down, then load and clear together.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
        check_output("load clamp q", int'(dq[2]), 5);
        check_output("load unclamped q", int'(dq[0]), 7);
        check_output("load wrap", int'(dw[2]), 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        check_output("down after load", int'(dq[2]), 4);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd3);
        check_output("sclr+load q", int'(dq[2]), 0);

        // Prescale by three with a pause in the middle.
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        check_output("prescale hold", int'(dq[3]), 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        check_output("prescale step", int'(dq[3]), 1);
        check_output("no prescale q", int'(dq[0]), 3);

        // Asynchronous reset between edges.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 3'd6);
        check_output("load 6", int'(dq[0]), 6);
        en = 1'b1; up_dn = 1'b1; load = 1'b0;
        rst = 1'b0;
        #1;
        check_output("async rst q", int'(dq[0]), 0);
        check_output("async rst wrap", int'(dw[0]), 0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #2;
        check_output("after rst q", int'(dq[0]), 1);
        check_output("after rst prescale q", int'(dq[3]), 0);

        // Mixed directed vectors, checked by the model only.
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(mix[k].e, mix[k].u, mix[k].s, mix[k].l, mix[k].v);
        end

        @(negedge clk);
        #1;
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
